// File: rtl/nonce_sequencer.sv
// nonce_sequencer: issues nonces to the hash core on phase 0 and checks each hash against the target on the last phase
module nonce_sequencer #(
   parameter int PERIOD  = 34,
   parameter int NONCE_W = 32,
   parameter int HASH_W  = 24,
   parameter int TGT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         counter,
   input  logic               start,
   input  logic [NONCE_W-1:0] nonce_first,
   input  logic [NONCE_W-1:0] nonce_last,
   input  logic [TGT_W-1:0]   target,
   input  logic [HASH_W-1:0]  hash_in,
   input  logic               ack,
   output logic [NONCE_W-1:0] nonce,
   output logic               nonce_valid,
   output logic               busy,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic               done
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ALIGN     = 3'd1;
   localparam logic [2:0] RUN       = 3'd2;
   localparam logic [2:0] DONE_HIT  = 3'd3;
   localparam logic [2:0] DONE_MISS = 3'd4;
   localparam logic [5:0] PH_LAST   = 6'(PERIOD - 1);

   logic [2:0]         state, state_nx;
   logic [NONCE_W-1:0] last_q;
   logic [TGT_W-1:0]   target_q;
   logic               ph0, phl, hit, at_last;

   // MSBs < target is the same as the full hash < target shifted up to the MSBs
   always_comb begin
      ph0      = counter == 6'd0;
      phl      = counter == PH_LAST;
      hit      = hash_in < {target_q, {(HASH_W-TGT_W){1'b0}}};
      at_last  = nonce == last_q;
      state_nx = state;
      case (state)
         IDLE:                state_nx = start ? ALIGN : IDLE;
         ALIGN:               state_nx = phl ? RUN : ALIGN;
         RUN:                 state_nx = !phl ? RUN : hit ? DONE_HIT : at_last ? DONE_MISS : RUN;
         DONE_HIT, DONE_MISS: state_nx = ack ? IDLE : state;
         default:             state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         nonce       <= '0;
         nonce_valid <= 1'b0;
         busy        <= 1'b0;
         found       <= 1'b0;
         found_nonce <= '0;
         done        <= 1'b0;
         last_q      <= '0;
         target_q    <= '0;
      end else begin
         state       <= state_nx;
         busy        <= state_nx == ALIGN || state_nx == RUN;
         found       <= state_nx == DONE_HIT;
         done        <= state_nx == DONE_HIT || state_nx == DONE_MISS;
         nonce_valid <= state == RUN && ph0;
         if (state == IDLE && start) begin
            nonce    <= nonce_first;
            last_q   <= nonce_last;
            target_q <= target;
         end
         if (state == RUN && phl) begin
            if (hit) found_nonce <= nonce;
            else if (!at_last) nonce <= nonce + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_nonce_sequencer.sv
// tb_nonce_sequencer: directed and randomized searches checked against a list-based model of the nonce search
module tb_nonce_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  counter = 6'd0;
   logic        start = 1'b0;
   logic [31:0] nonce_first = '0;
   logic [31:0] nonce_last = '0;
   logic [7:0]  target = '0;
   logic [23:0] hash_in = '0;
   logic        ack = 1'b0;
   logic [31:0] nonce;
   logic        nonce_valid, busy, found, done;
   logic [31:0] found_nonce;

   int checks = 0;
   int errors = 0;
   int n33 = 0;
   int caps = 0;
   int stall_n = 0;
   logic [5:0]  ctr = 6'd0;
   logic [5:0]  cs;
   logic [7:0]  hq[$];
   logic [31:0] exp_list[$];

   nonce_sequencer dut (
      .clk(clk), .reset(reset), .counter(counter), .start(start),
      .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
      .hash_in(hash_in), .ack(ack), .nonce(nonce), .nonce_valid(nonce_valid),
      .busy(busy), .found(found), .found_nonce(found_nonce), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   // one clock: record the phase the DUT saw, then drive the next phase and hash
   task automatic tick();
      logic [31:0] r;
      @(posedge clk);
      cs = counter;
      #1;
      if (stall_n > 0) begin
         stall_n--;
         counter = 6'd40;
      end else begin
         ctr = (ctr == 6'd33) ? 6'd0 : ctr + 6'd1;
         counter = ctr;
      end
      r = $urandom;
      hash_in = (counter == 6'd33 && n33 > 0 && caps < hq.size()) ? {hq[caps], r[15:0]} : r[23:0];
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_nonce"}, nonce, 0);
      chk({tag, "_valid"}, {31'd0, nonce_valid}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_found"}, {31'd0, found}, 0);
      chk({tag, "_fnonce"}, found_nonce, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
   endtask

   task automatic run_search(input logic [31:0] f, input logic [31:0] l, input logic [7:0] t, input int stall_at);
      logic [31:0] n;
      bit hit, fin, exp_v;
      int len, strobes, lim;
      n = f;
      hit = 0;
      exp_list.delete();
      for (int k = 0; k < 1000; k++) begin
         exp_list.push_back(n);
         if (k < hq.size() && hq[k] < t) begin
            hit = 1;
            break;
         end
         if (n == l) break;
         n++;
      end
      len = exp_list.size();
      lim = 34 * (len + 3) + 10;
      n33 = 0;
      caps = 0;
      strobes = 0;
      fin = 0;
      nonce_first = f;
      nonce_last = l;
      target = t;
      start = 1'b1;
      tick();
      start = 1'b0;
      nonce_first = $urandom;
      nonce_last = $urandom;
      target = 8'($urandom);
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_nonce", nonce, f);
      for (int c = 0; c < lim && !fin; c++) begin
         tick();
         if (c == stall_at) stall_n = 5;
         start = counter == 6'd40;
         ack = counter == 6'd40;
         if (cs == 6'd33) begin
            if (n33 > 0) caps++;
            n33++;
         end
         exp_v = cs == 6'd0 && n33 > 0 && caps < len;
         fin = caps == len;
         chk("strobe", {31'd0, nonce_valid}, {31'd0, exp_v});
         if (nonce_valid && exp_v) begin
            chk("issued", nonce, exp_list[strobes]);
            strobes++;
         end
         chk("nonce_hold", nonce, exp_list[caps < len ? caps : len - 1]);
         chk("busy", {31'd0, busy}, {31'd0, !fin});
         chk("done", {31'd0, done}, {31'd0, fin});
      end
      start = 1'b0;
      ack = 1'b0;
      chk("search_done", {31'd0, done}, 1);
      chk("strobe_count", strobes, len);
      for (int c = 0; c < 3; c++) begin
         chk("found", {31'd0, found}, {31'd0, hit});
         if (hit) chk("found_nonce", found_nonce, exp_list[len - 1]);
         chk("done_hold", {31'd0, done}, 1);
         chk("no_strobe", {31'd0, nonce_valid}, 0);
         if (c < 2) tick();
      end
      start = 1'b1;
      ack = 1'b1;
      tick();
      start = 1'b0;
      ack = 1'b0;
      chk("ack_done", {31'd0, done}, 0);
      chk("ack_found", {31'd0, found}, 0);
      chk("ack_busy", {31'd0, busy}, 0);
      tick();
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_nonce", nonce, exp_list[len - 1]);
   endtask

   initial begin
      logic [7:0]  t;
      logic [31:0] f;
      bit seen;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk_idle_zero("reset");

      hq = '{8'hFF, 8'hFF, 8'hFF};
      run_search(32'd5, 32'd7, 8'h10, -1);

      hq = '{8'($urandom_range(8'h10, 8'hFF)), 8'($urandom_range(8'h10, 8'hFF)), 8'h0F};
      run_search(32'd100, 32'd200, 8'h10, -1);

      hq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_search(32'hFFFF_FFFE, 32'd1, 8'h10, -1);

      t = 8'($urandom_range(1, 255));
      hq = '{t - 8'd1};
      run_search(32'd42, 32'd42, t, -1);
      hq = '{t};
      run_search(32'd42, 32'd42, t, -1);

      hq.delete();
      for (int i = 0; i < 8; i++) hq.push_back(8'($urandom));
      f = $urandom;
      run_search(f, f + 32'd3, 8'd0, 50);

      hq.delete();
      n33 = 0;
      nonce_first = 32'd1000;
      nonce_last = 32'd2000;
      target = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 80 && !seen; c++) begin
         tick();
         seen = nonce_valid;
      end
      chk("pre_reset_strobe", {31'd0, nonce_valid}, 1);
      for (int c = 0; c < 40 && counter != 6'd17; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrun_phase", {26'd0, cs}, 17);
      chk_idle_zero("midrun");
      tick();
      chk("post_reset_busy", {31'd0, busy}, 0);

      for (int r = 0; r < 3; r++) begin
         hq.delete();
         for (int i = 0; i < 8; i++) hq.push_back(8'($urandom));
         f = $urandom;
         run_search(f, f + 32'($urandom_range(0, 4)), 8'($urandom_range(0, 40)), (r == 1) ? 20 : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nonce_sequencer.md
Name: nonce_sequencer

Overview:
- Consumer side of the free-running 6-bit phase counter (0..33, wraps) in the speed/throughput path of the hash generator.
- Uses phase 0 to issue a nonce to the hash core and phase PERIOD-1 to capture that nonce's hash and compare it against a target.
- Steps nonces until a hit or range exhaustion, then reports the result on a hold-until-ack interface.

Parameters:
PERIOD, 34, phase count modulus; phase input runs 0..PERIOD-1
NONCE_W, 32, nonce width
HASH_W, 24, width of hash word returned by core
TGT_W, 8, width of target; compared against hash MSBs

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
counter  in  6  phase from free-running phase counter
start  in  1  launch search; sampled only in IDLE
nonce_first  in  NONCE_W  first nonce, latched on start
nonce_last  in  NONCE_W  last nonce, latched on start
target  in  TGT_W  hit threshold, latched on start
hash_in  in  HASH_W  hash of nonce issued at last phase 0; valid when counter==PERIOD-1
ack  in  1  clears a DONE state
nonce  out  NONCE_W  nonce presented to core
nonce_valid  out  1  1-cycle strobe, nonce issued this cycle
busy  out  1  high in ALIGN and RUN
found  out  1  high in DONE_HIT
found_nonce  out  NONCE_W  nonce that hit; held in DONE_HIT
done  out  1  high in DONE_HIT or DONE_MISS

Behaviour:
- Reset (synchronous; any state, mid-search included): state=IDLE. nonce=0, nonce_valid=0, busy=0, found=0, found_nonce=0, done=0. Latched first, last and target cleared to 0.
- All outputs are registered.
- IDLE: start=1 latches nonce_first, nonce_last and target, loads nonce=nonce_first, then goes to ALIGN. start is ignored in every other state.
- ALIGN: waits for counter==PERIOD-1, then goes to RUN. Consequence: the first issue always happens on a full, clean period.
- RUN, phase 0 (counter==0): nonce_valid=1 for exactly that cycle, nonce unchanged.
- RUN, phase PERIOD-1 (counter==PERIOD-1): evaluate hash_in[HASH_W-1 -: TGT_W] < target (unsigned).
  - Hit: found_nonce<=nonce, state DONE_HIT.
  - Miss with nonce==nonce_last: state DONE_MISS.
  - Miss otherwise: nonce<=nonce+1 (wraps mod 2^NONCE_W), stay in RUN.
- RUN, all other phases: hold.
- Phase values >=PERIOD (illegal) cause no action in any state.
- Issue-to-capture latency is PERIOD-1 cycles. One nonce per PERIOD cycles.
- nonce_first==nonce_last: exactly one nonce is tested.
- nonce_last<nonce_first: the search wraps through 2^NONCE_W-1 to 0 until it reaches nonce_last. This is legal.
- target==0: never hits; the search always ends in DONE_MISS.
- DONE_HIT: found=1, done=1, found_nonce held. ack=1 -> IDLE, next cycle found=0, done=0.
- DONE_MISS: found=0, done=1. ack=1 -> IDLE.
- ack in IDLE, ALIGN or RUN is ignored.
- start and ack asserted together in a DONE state: ack is honoured and start is ignored. A new start must come in IDLE.
- nonce output keeps its last value in IDLE and DONE states.

Test Plan:
- Reset mid-RUN at phase 17 -> next cycle all outputs 0, state IDLE. A later start restarts cleanly from nonce_first.
- start with first=5, last=7, target=0x10, hash MSBs always 0xFF -> nonce_valid strobes with nonce=5,6,7, 34 cycles apart, first strobe at the first counter==0 after ALIGN. Then done=1, found=0.
- first=100, last=200, target=0x10, hash MSB=0x0F on the 3rd capture -> found=1, done=1, found_nonce=102, no further nonce_valid. ack -> done=0, found=0 next cycle.
- first=0xFFFFFFFE, last=1, always miss -> issued nonces FFFFFFFE, FFFFFFFF, 0, 1, then DONE_MISS.
- Single nonce first=last=42 with hash MSB==target-1 -> hit, found_nonce=42. Repeat with hash MSB==target -> DONE_MISS.
- start pulsed during RUN, ack pulsed during RUN, counter forced to 40 for several cycles -> no state change, no strobe, no nonce increment.
